// File: rtl/mxint_accumulator_pkg.sv
// Shared constants and helpers for the MXINT accumulator slice.
// Holds default widths and the beat-counter width helper.
package mxint_accumulator_pkg;

   localparam int MXINT_MAN_W_DEF       = 8;
   localparam int MXINT_EXP_W_DEF       = 8;
   localparam int MXINT_BLOCK_COUNT_DEF = 4;

   // A counter for a single-beat group still needs one bit to exist.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mxint_align_shift.sv
// Arithmetic right shift used to align MXINT mantissas.
// Shifts of WIDTH or more collapse to pure sign fill (0 or -1).
module mxint_align_shift #(
   parameter int WIDTH   = 10,
   parameter int SHIFT_W = 9
) (
   input  logic signed [WIDTH-1:0]   data_i,
   input  logic        [SHIFT_W-1:0] shamt_i,
   output logic signed [WIDTH-1:0]   data_o
);

   always_comb begin
      if (32'(shamt_i) >= 32'(WIDTH)) begin
         data_o = {WIDTH{data_i[WIDTH-1]}};
      end else begin
         data_o = data_i >>> shamt_i;
      end
   end

endmodule

// File: rtl/mxint_accumulator.sv
// Sums BLOCK_COUNT MXINT partial sums (mantissa + shared exponent) into one result.
// The smaller-exponent operand is aligned to the larger exponent before each add.
module mxint_accumulator
   import mxint_accumulator_pkg::*;
#(
   parameter int DATA_IN_0_PRECISION_0  = MXINT_MAN_W_DEF,
   parameter int DATA_IN_0_PRECISION_1  = MXINT_EXP_W_DEF,
   parameter int BLOCK_COUNT            = MXINT_BLOCK_COUNT_DEF,
   parameter int DATA_OUT_0_PRECISION_0 = DATA_IN_0_PRECISION_0 + $clog2(BLOCK_COUNT),
   parameter int DATA_OUT_0_PRECISION_1 = DATA_IN_0_PRECISION_1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [DATA_IN_0_PRECISION_0-1:0]  mdata_in_0,
   input  logic [DATA_IN_0_PRECISION_1-1:0]  edata_in_0,
   input  logic                              data_in_0_valid,
   output logic                              data_in_0_ready,
   output logic [DATA_OUT_0_PRECISION_0-1:0] mdata_out_0,
   output logic [DATA_OUT_0_PRECISION_1-1:0] edata_out_0,
   output logic                              data_out_0_valid,
   input  logic                              data_out_0_ready
);

   localparam int IW    = DATA_IN_0_PRECISION_0;
   localparam int EW    = DATA_IN_0_PRECISION_1;
   localparam int OW    = DATA_OUT_0_PRECISION_0;
   localparam int OEW   = DATA_OUT_0_PRECISION_1;
   localparam int DW    = EW + 1;
   localparam int CNT_W = cnt_width(BLOCK_COUNT);

   typedef enum logic {ACCUM, OUTPUT} state_e;

   state_e                  state_q;
   logic [CNT_W-1:0]        cnt_q;
   logic signed [OW-1:0]    acc_m_q;
   logic [EW-1:0]           acc_e_q;
   logic [OW-1:0]           mdata_out_q;
   logic [OEW-1:0]          edata_out_q;

   logic                    in_fire;
   logic                    out_fire;
   logic                    first_beat;
   logic                    last_beat;
   logic signed [IW-1:0]    m_in_s;
   logic signed [OW-1:0]    ext_m;
   logic signed [DW-1:0]    e_diff;
   logic                    in_exp_gt;
   logic [DW-1:0]           shamt;
   logic signed [OW-1:0]    shift_src;
   logic signed [OW-1:0]    shifted;
   logic signed [OW-1:0]    addend;
   logic signed [OW-1:0]    acc_m_d;
   logic signed [EW-1:0]    acc_e_d;
   logic [OEW-1:0]          edata_out_d;

   // valid is the registered OUTPUT state; ready never looks at input valid
   assign data_out_0_valid = (state_q == OUTPUT);
   assign data_in_0_ready  = !data_out_0_valid || data_out_0_ready;
   assign in_fire          = data_in_0_valid && data_in_0_ready;
   assign out_fire         = data_out_0_valid && data_out_0_ready;
   assign first_beat       = (cnt_q == '0);
   assign last_beat        = (cnt_q == CNT_W'(BLOCK_COUNT - 1));

   assign mdata_out_0 = mdata_out_q;
   assign edata_out_0 = edata_out_q;

   assign m_in_s = mdata_in_0;
   assign ext_m  = OW'(m_in_s);

   // Signed exponent difference with one guard bit so it never overflows.
   assign e_diff    = {edata_in_0[EW-1], edata_in_0} - {acc_e_q[EW-1], acc_e_q};
   assign in_exp_gt = !e_diff[DW-1] && (e_diff != '0);
   assign shamt     = in_exp_gt ? e_diff : (~e_diff + DW'(1));
   assign shift_src = in_exp_gt ? acc_m_q : ext_m;
   assign addend    = in_exp_gt ? ext_m : acc_m_q;

   mxint_align_shift #(
      .WIDTH   (OW),
      .SHIFT_W (DW)
   ) u_align (
      .data_i  (shift_src),
      .shamt_i (shamt),
      .data_o  (shifted)
   );

   always_comb begin
      acc_m_d = shifted + addend;
      acc_e_d = in_exp_gt ? edata_in_0 : acc_e_q;
      if (first_beat) begin
         acc_m_d = ext_m;
         acc_e_d = edata_in_0;
      end
      edata_out_d = OEW'(acc_e_d);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ACCUM;
         cnt_q       <= '0;
         acc_m_q     <= '0;
         acc_e_q     <= '0;
         mdata_out_q <= '0;
         edata_out_q <= '0;
      end else begin
         if (out_fire) begin
            state_q <= ACCUM;
         end
         if (in_fire) begin
            acc_m_q <= acc_m_d;
            acc_e_q <= acc_e_d;
            cnt_q   <= last_beat ? '0 : cnt_q + CNT_W'(1);
            // Closing beat publishes the sum; overrides the consume above.
            if (last_beat) begin
               mdata_out_q <= acc_m_d;
               edata_out_q <= edata_out_d;
               state_q     <= OUTPUT;
            end
         end
      end
   end

endmodule

// File: tb/tb_mxint_accumulator.sv
// Bench for mxint_accumulator: random and directed groups, scoreboarded against
// an integer model of the MXINT alignment/accumulation rules.
module tb_mxint_accumulator;

   localparam int IW  = 8;
   localparam int EW  = 8;
   localparam int BC  = 4;
   localparam int OW  = 10;
   localparam int OEW = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [IW-1:0]  mdata_in_0 = '0;
   logic [EW-1:0]  edata_in_0 = '0;
   logic           data_in_0_valid = 1'b0;
   logic           data_in_0_ready;
   logic [OW-1:0]  mdata_out_0;
   logic [OEW-1:0] edata_out_0;
   logic           data_out_0_valid;
   logic           data_out_0_ready = 1'b1;

   always #5 clk = ~clk;

   mxint_accumulator #(
      .DATA_IN_0_PRECISION_0  (IW),
      .DATA_IN_0_PRECISION_1  (EW),
      .BLOCK_COUNT            (BC),
      .DATA_OUT_0_PRECISION_0 (OW),
      .DATA_OUT_0_PRECISION_1 (OEW)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .mdata_in_0       (mdata_in_0),
      .edata_in_0       (edata_in_0),
      .data_in_0_valid  (data_in_0_valid),
      .data_in_0_ready  (data_in_0_ready),
      .mdata_out_0      (mdata_out_0),
      .edata_out_0      (edata_out_0),
      .data_out_0_valid (data_out_0_valid),
      .data_out_0_ready (data_out_0_ready)
   );

   logic [OEW+OW-1:0] exp_q[$];
   int grp_m[$];
   int grp_e[$];
   int n_checks = 0;
   int n_pass   = 0;
   int ready_mode = 0;
   int stall_cnt  = 0;
   bit lat_pending = 1'b0;

   task automatic check(input string name, input int act, input int exp_v);
      n_checks++;
      if (act == exp_v) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
   endtask

   // Two's-complement wrap of an integer into OW bits.
   function automatic int wrap_ow(input int v);
      int modv;
      int r;
      modv = 1 << OW;
      r = ((v % modv) + modv) % modv;
      if (r >= modv / 2) r -= modv;
      return r;
   endfunction

   // Floor division by 2^s, saturating to the sign once s reaches OW.
   function automatic int align(input int v, input int s);
      if (s >= OW) return (v < 0) ? -1 : 0;
      return v >>> s;
   endfunction

   task automatic model_group_done();
      int m;
      int e;
      logic [OW-1:0]  mm;
      logic [OEW-1:0] ee;
      m = grp_m[0];
      e = grp_e[0];
      for (int i = 1; i < BC; i++) begin
         if (grp_e[i] > e) begin
            m = wrap_ow(align(m, grp_e[i] - e) + grp_m[i]);
            e = grp_e[i];
         end else begin
            m = wrap_ow(m + align(grp_m[i], e - grp_e[i]));
         end
      end
      mm = m[OW-1:0];
      ee = e[OEW-1:0];
      exp_q.push_back({ee, mm});
      grp_m.delete();
      grp_e.delete();
   endtask

   // Called at posedge+1; returns at posedge+1 right after the beat is taken.
   task automatic send(input int m, input int e);
      int  waited;
      bit  taken;
      waited = 0;
      taken  = 1'b0;
      data_in_0_valid = 1'b1;
      mdata_in_0 = m[IW-1:0];
      edata_in_0 = e[EW-1:0];
      while (!taken && waited < 200) begin
         @(negedge clk);
         taken = data_in_0_ready;
         @(posedge clk);
         #1;
         waited++;
      end
      data_in_0_valid = 1'b0;
      if (!taken) begin
         check("accept_timeout", 0, 1);
      end else begin
         grp_m.push_back(m);
         grp_e.push_back(e);
         if (grp_m.size() == BC) begin
            model_group_done();
            lat_pending = 1'b1;
         end
      end
   endtask

   task automatic send_rand();
      int m;
      int e;
      m = int'($urandom_range(0, 255)) - 128;
      if ($urandom_range(0, 3) == 0) e = int'($urandom_range(0, 255)) - 128;
      else e = int'($urandom_range(0, 16)) - 8;
      send(m, e);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_pending", exp_q.size(), 0);
   endtask

   // Output must be valid in the cycle right after the closing beat.
   always @(negedge clk) begin
      if (lat_pending) begin
         check("latency_valid", int'(data_out_0_valid), 1);
         lat_pending = 1'b0;
      end
   end

   // Monitor: drives output ready, checks handshake rules and pops the scoreboard.
   initial begin
      bit             held;
      logic [OW-1:0]  held_m;
      logic [OEW-1:0] held_e;
      logic [OEW+OW-1:0] exp_v;
      held = 1'b0;
      held_m = '0;
      held_e = '0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            1: data_out_0_ready = ($urandom_range(0, 3) != 0);
            2: begin
               if (data_out_0_valid && stall_cnt < 5) begin
                  data_out_0_ready = 1'b0;
                  stall_cnt++;
               end else begin
                  data_out_0_ready = 1'b1;
               end
            end
            default: data_out_0_ready = 1'b1;
         endcase
         @(negedge clk);
         if (rst) begin
            check("in_ready_rule", int'(data_in_0_ready),
                  int'(!data_out_0_valid || data_out_0_ready));
            if (held) begin
               check("hold_mant", int'(mdata_out_0), int'(held_m));
               check("hold_exp", int'(edata_out_0), int'(held_e));
            end
            if (data_out_0_valid && data_out_0_ready) begin
               held = 1'b0;
               if (exp_q.size() == 0) begin
                  check("unexpected_output", 0, 1);
               end else begin
                  exp_v = exp_q.pop_front();
                  check("out_mant", int'($signed(mdata_out_0)), int'($signed(exp_v[OW-1:0])));
                  check("out_exp", int'($signed(edata_out_0)), int'($signed(exp_v[OEW+OW-1:OW])));
               end
            end else if (data_out_0_valid) begin
               held   = 1'b1;
               held_m = mdata_out_0;
               held_e = edata_out_0;
            end else begin
               held = 1'b0;
            end
         end else begin
            held = 1'b0;
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_valid", int'(data_out_0_valid), 0);
      check("reset_mant", int'(mdata_out_0), 0);
      check("reset_exp", int'(edata_out_0), 0);
      check("reset_in_ready", int'(data_in_0_ready), 1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Equal, rising, falling/mixed and very large exponent differences.
      send(10, 3);   send(20, 3);  send(30, 3);  send(40, 3);
      send(8, 0);    send(8, 1);   send(8, 2);   send(8, 3);
      send(16, 5);   send(16, 3);  send(-16, 5); send(4, 5);
      send(-100, 0); send(1, 20);  send(0, 20);  send(0, 20);
      send(127, -128); send(127, -128); send(127, -128); send(127, -128);
      drain();

      // Five-cycle output stall with the next group already pushing.
      stall_cnt  = 0;
      ready_mode = 2;
      for (int i = 0; i < 2 * BC; i++) send_rand();
      drain();

      // Random traffic with random backpressure and idle gaps.
      ready_mode = 1;
      for (int i = 0; i < 40 * BC; i++) begin
         send_rand();
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      drain();

      // Reset in the middle of a group throws the partial sum away.
      ready_mode = 0;
      send(50, 2);
      send(60, 7);
      #2;
      rst = 1'b0;
      #1;
      check("midreset_valid", int'(data_out_0_valid), 0);
      check("midreset_in_ready", int'(data_in_0_ready), 1);
      grp_m.delete();
      grp_e.delete();
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < BC; i++) send(1, 0);
      drain();

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
